// File: rtl/sdmac_pkg.sv
// sdmac_pkg: shared types and constants for the SCSI peripheral port arbiter
package sdmac_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_e;
  typedef enum logic {REQ_CPU, REQ_DMA} req_e;
  // chip selects packed as {_CSX1, _CSX0, _CSS}, active low
  localparam logic [2:0] CS_SCSI = 3'b110;
  localparam logic [2:0] CS_X0   = 3'b101;
  localparam logic [2:0] CS_X1   = 3'b011;
  localparam logic [2:0] CS_NONE = 3'b111;
  // byte address bits [6:4] of the 0x40 / 0x60 / 0x70 windows
  localparam logic [2:0] ADDR_SCSI = 3'b100;
  localparam logic [2:0] ADDR_X0   = 3'b110;
  localparam logic [2:0] ADDR_X1   = 3'b111;
  // 0x40-0x5F share _CSS, so only the top two bits are compared for it
  function automatic logic [2:0] decode_cs(input logic [2:0] a);
    return a[2:1] == ADDR_SCSI[2:1] ? CS_SCSI :
           a == ADDR_X0 ? CS_X0 :
           a == ADDR_X1 ? CS_X1 : CS_NONE;
  endfunction
endpackage

// File: rtl/port_cycle_timer.sv
// port_cycle_timer: loadable 4-bit down-counter, done marks the last cycle of a phase
module port_cycle_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ld_i,
  input  logic [3:0] val_i,
  output logic [3:0] cnt_o,
  output logic       done_o
);
  logic [3:0] cnt_q;
  // load on phase entry, then count down to one and stop at zero
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else if (ld_i) cnt_q <= val_i;
    else if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
  end
  assign cnt_o  = cnt_q;
  assign done_o = cnt_q == 4'd1;
endmodule

// File: rtl/scsi_port_arbiter.sv
// scsi_port_arbiter: round-robin CPU/DMA sharing of the peripheral port with timed strobe cycles
module scsi_port_arbiter
  import sdmac_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CPU_REQ,
  input  logic        CPU_RW,
  input  logic [4:0]  CPU_ADDR,
  input  logic [15:0] CPU_WDATA,
  output logic        CPU_ACK,
  output logic [15:0] CPU_RDATA,
  input  logic        DMA_REQ,
  input  logic        DMA_RW,
  input  logic [15:0] DMA_WDATA,
  output logic        DMA_ACK,
  output logic [15:0] DMA_RDATA,
  output logic        _CSS,
  output logic        _CSX0,
  output logic        _CSX1,
  output logic        _IOR,
  output logic        _IOW,
  output logic [15:0] PD_OUT,
  output logic        PD_OE,
  input  logic [15:0] PD_IN
);
  state_e      state_q;
  req_e        last_q, who_q;
  logic        rw_q, ior_q, iow_q, pd_oe_q, cpu_ack_q, dma_ack_q;
  logic [2:0]  cs_q, cpu_cs;
  logic [15:0] pd_out_q, cpu_rdata_q, dma_rdata_q;
  logic        arb_ok, cpu_win, dma_win, tmr_ld, tmr_done;
  logic [3:0]  tmr_val, tmr_cnt;
  logic        unused_addr;
  assign unused_addr = ^CPU_ADDR[1:0];
  port_cycle_timer u_timer (
    .clk_i (CLK),
    .rst_i (RST),
    .ld_i  (tmr_ld),
    .val_i (tmr_val),
    .cnt_o (tmr_cnt),
    .done_o(tmr_done)
  );
  // arbitration is held off while an ACK is showing so IDLE lasts a full cycle
  always_comb begin
    arb_ok  = state_q == ST_IDLE && !cpu_ack_q && !dma_ack_q;
    cpu_cs  = decode_cs(CPU_ADDR[4:2]);
    cpu_win = arb_ok && CPU_REQ && (!DMA_REQ || last_q == REQ_DMA);
    dma_win = arb_ok && DMA_REQ && !cpu_win;
    tmr_ld  = (cpu_win && cpu_cs != CS_NONE) || dma_win ||
              (tmr_done && (state_q == ST_SETUP || state_q == ST_STROBE));
    tmr_val = state_q == ST_IDLE  ? 4'(SETUP_CYC) :
              state_q == ST_SETUP ? 4'(STROBE_CYC) : 4'(HOLD_CYC);
  end
  // cycle FSM; every pin is registered and set on the edge that enters its phase
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      last_q      <= REQ_DMA;
      who_q       <= REQ_CPU;
      rw_q        <= 1'b0;
      cs_q        <= CS_NONE;
      ior_q       <= 1'b1;
      iow_q       <= 1'b1;
      pd_oe_q     <= 1'b0;
      pd_out_q    <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_win) begin
            last_q <= REQ_CPU;
            if (cpu_cs == CS_NONE) begin
              cpu_ack_q   <= 1'b1;
              cpu_rdata_q <= '0;
            end else begin
              state_q <= ST_SETUP;
              who_q   <= REQ_CPU;
              rw_q    <= CPU_RW;
              cs_q    <= cpu_cs;
              pd_oe_q <= !CPU_RW;
              if (!CPU_RW) pd_out_q <= CPU_WDATA;
            end
          end else if (dma_win) begin
            last_q  <= REQ_DMA;
            state_q <= ST_SETUP;
            who_q   <= REQ_DMA;
            rw_q    <= DMA_RW;
            cs_q    <= CS_X0;
            pd_oe_q <= !DMA_RW;
            if (!DMA_RW) pd_out_q <= DMA_WDATA;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            state_q <= ST_STROBE;
            ior_q   <= !rw_q;
            iow_q   <= rw_q;
          end
        end
        ST_STROBE: begin
          if (tmr_done) begin
            state_q <= ST_HOLD;
            ior_q   <= 1'b1;
            iow_q   <= 1'b1;
            if (rw_q && who_q == REQ_CPU) cpu_rdata_q <= PD_IN;
            if (rw_q && who_q == REQ_DMA) dma_rdata_q <= PD_IN;
            if (HOLD_CYC == 1) begin
              cpu_ack_q <= who_q == REQ_CPU;
              dma_ack_q <= who_q == REQ_DMA;
            end
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            state_q <= ST_IDLE;
            cs_q    <= CS_NONE;
            pd_oe_q <= 1'b0;
          end else if (tmr_cnt == 4'd2) begin
            cpu_ack_q <= who_q == REQ_CPU;
            dma_ack_q <= who_q == REQ_DMA;
          end
        end
      endcase
    end
  end
  assign {_CSX1, _CSX0, _CSS} = cs_q;
  assign _IOR      = ior_q;
  assign _IOW      = iow_q;
  assign PD_OE     = pd_oe_q;
  assign PD_OUT    = pd_out_q;
  assign CPU_ACK   = cpu_ack_q;
  assign DMA_ACK   = dma_ack_q;
  assign CPU_RDATA = cpu_rdata_q;
  assign DMA_RDATA = dma_rdata_q;
endmodule

// File: tb/tb_scsi_port_arbiter.sv
// tb_scsi_port_arbiter: directed scenarios for the SCSI port arbiter
module tb_scsi_port_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CPU_REQ = 1'b0, CPU_RW = 1'b0;
  logic [4:0]  CPU_ADDR = '0;
  logic [15:0] CPU_WDATA = '0;
  logic        CPU_ACK;
  logic [15:0] CPU_RDATA;
  logic        DMA_REQ = 1'b0, DMA_RW = 1'b0;
  logic [15:0] DMA_WDATA = '0;
  logic        DMA_ACK;
  logic [15:0] DMA_RDATA;
  logic        _CSS, _CSX0, _CSX1, _IOR, _IOW, PD_OE;
  logic [15:0] PD_OUT;
  logic [15:0] PD_IN = '0;
  int checks = 0;
  int failures = 0;
  scsi_port_arbiter dut (
    .CLK(CLK), .RST(RST),
    .CPU_REQ(CPU_REQ), .CPU_RW(CPU_RW), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
    .DMA_REQ(DMA_REQ), .DMA_RW(DMA_RW), .DMA_WDATA(DMA_WDATA),
    .DMA_ACK(DMA_ACK), .DMA_RDATA(DMA_RDATA),
    ._CSS(_CSS), ._CSX0(_CSX0), ._CSX1(_CSX1), ._IOR(_IOR), ._IOW(_IOW),
    .PD_OUT(PD_OUT), .PD_OE(PD_OE), .PD_IN(PD_IN)
  );
  always #5 CLK = ~CLK;
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset;
    RST = 1'b1;
    CPU_REQ = 1'b1;
    DMA_REQ = 1'b1;
    repeat (3) step;
    checks++;
    if ({_CSS, _CSX0, _CSX1, _IOR, _IOW} !== 5'b11111) begin
      failures++;
      $display("FAIL reset_pins got=%b exp=11111", {_CSS, _CSX0, _CSX1, _IOR, _IOW});
    end
    checks++;
    if ({PD_OE, CPU_ACK, DMA_ACK} !== 3'b000) begin
      failures++;
      $display("FAIL reset_oe_acks got=%b exp=000", {PD_OE, CPU_ACK, DMA_ACK});
    end
    checks++;
    if ({PD_OUT, CPU_RDATA, DMA_RDATA} !== 48'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {PD_OUT, CPU_RDATA, DMA_RDATA});
    end
    RST = 1'b0;
    CPU_REQ = 1'b0;
    DMA_REQ = 1'b0;
    step;
    checks++;
    if ({_CSS, _CSX0, _CSX1, _IOR, _IOW, PD_OE} !== 6'b111110) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=111110", {_CSS, _CSX0, _CSX1, _IOR, _IOW, PD_OE});
    end
  endtask
  task automatic test_cpu_write;
    logic [8:1] css_v, oth_v, iow_v, ack_v, oe_v;
    logic [15:0] pd3;
    CPU_RW = 1'b0;
    CPU_ADDR = 5'h10;
    CPU_WDATA = 16'hFF40;
    CPU_REQ = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step;
      css_v[i] = _CSS;
      oth_v[i] = _CSX0 & _CSX1 & _IOR & ~DMA_ACK;
      iow_v[i] = _IOW;
      ack_v[i] = CPU_ACK;
      oe_v[i] = PD_OE;
      if (i == 3) pd3 = PD_OUT;
      if (CPU_ACK) CPU_REQ = 1'b0;
    end
    checks++;
    if (css_v !== 8'b11100000) begin failures++; $display("FAIL wr_css got=%b exp=11100000", css_v); end
    checks++;
    if (iow_v !== 8'b11110001) begin failures++; $display("FAIL wr_iow got=%b exp=11110001", iow_v); end
    checks++;
    if (ack_v !== 8'b00010000) begin failures++; $display("FAIL wr_ack got=%b exp=00010000", ack_v); end
    checks++;
    if (oe_v !== 8'b00011111) begin failures++; $display("FAIL wr_oe got=%b exp=00011111", oe_v); end
    checks++;
    if (pd3 !== 16'hFF40) begin failures++; $display("FAIL wr_pdout got=%h exp=ff40", pd3); end
    checks++;
    if (oth_v !== 8'hFF) begin failures++; $display("FAIL wr_other got=%b exp=11111111", oth_v); end
  endtask
  task automatic test_cpu_read;
    logic [8:1] cs_v, oth_v, ior_v, ack_v, oe_v;
    logic [15:0] rd_ack, rd_after;
    PD_IN = 16'h1234;
    CPU_RW = 1'b1;
    CPU_ADDR = 5'h1C;
    CPU_REQ = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step;
      cs_v[i] = _CSX1;
      oth_v[i] = _CSS & _CSX0 & _IOW;
      ior_v[i] = _IOR;
      ack_v[i] = CPU_ACK;
      oe_v[i] = PD_OE;
      if (i == 5) rd_ack = CPU_RDATA;
      if (i == 7) rd_after = CPU_RDATA;
      if (CPU_ACK) CPU_REQ = 1'b0;
    end
    PD_IN = 16'h0;
    checks++;
    if (cs_v !== 8'b11100000) begin failures++; $display("FAIL rd_csx1 got=%b exp=11100000", cs_v); end
    checks++;
    if (ior_v !== 8'b11110001) begin failures++; $display("FAIL rd_ior got=%b exp=11110001", ior_v); end
    checks++;
    if (ack_v !== 8'b00010000) begin failures++; $display("FAIL rd_ack got=%b exp=00010000", ack_v); end
    checks++;
    if (oe_v !== 8'h00) begin failures++; $display("FAIL rd_oe got=%b exp=00000000", oe_v); end
    checks++;
    if (oth_v !== 8'hFF) begin failures++; $display("FAIL rd_other got=%b exp=11111111", oth_v); end
    checks++;
    if (rd_ack !== 16'h1234) begin failures++; $display("FAIL rd_data got=%h exp=1234", rd_ack); end
    checks++;
    if (rd_after !== 16'h1234) begin failures++; $display("FAIL rd_hold got=%h exp=1234", rd_after); end
  endtask
  task automatic test_decode_miss;
    logic [4:1] ack_v, pins_v;
    logic [15:0] rd1;
    PD_IN = 16'hBEEF;
    CPU_RW = 1'b1;
    CPU_ADDR = 5'h04;
    CPU_REQ = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step;
      ack_v[i] = CPU_ACK;
      pins_v[i] = _CSS & _CSX0 & _CSX1 & _IOR & _IOW & ~PD_OE;
      if (i == 1) rd1 = CPU_RDATA;
      if (CPU_ACK) CPU_REQ = 1'b0;
    end
    PD_IN = 16'h0;
    checks++;
    if (ack_v !== 4'b0001) begin failures++; $display("FAIL miss_ack got=%b exp=0001", ack_v); end
    checks++;
    if (pins_v !== 4'b1111) begin failures++; $display("FAIL miss_pins got=%b exp=1111", pins_v); end
    checks++;
    if (rd1 !== 16'h0) begin failures++; $display("FAIL miss_rdata got=%h exp=0000", rd1); end
  endtask
  task automatic test_round_robin;
    logic [24:1] css_v, x0_v, cack_v, dack_v, e_css, e_x0, e_cack, e_dack;
    int multi;
    multi = 0;
    RST = 1'b1;
    step;
    RST = 1'b0;
    step;
    CPU_RW = 1'b0;
    CPU_ADDR = 5'h10;
    CPU_WDATA = 16'hC0C0;
    DMA_RW = 1'b0;
    DMA_WDATA = 16'h0D0D;
    CPU_REQ = 1'b1;
    DMA_REQ = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step;
      css_v[i] = _CSS;
      x0_v[i] = _CSX0;
      cack_v[i] = CPU_ACK;
      dack_v[i] = DMA_ACK;
      if (int'(!_CSS) + int'(!_CSX0) + int'(!_CSX1) > 1) multi++;
      e_css[i] = !((i - 1) % 12 < 5);
      e_x0[i] = !((i - 1) % 12 >= 6 && (i - 1) % 12 < 11);
      e_cack[i] = i == 5 || i == 17;
      e_dack[i] = i == 11 || i == 23;
      if (i == 24) begin
        CPU_REQ = 1'b0;
        DMA_REQ = 1'b0;
      end
    end
    step;
    checks++;
    if (css_v !== e_css) begin failures++; $display("FAIL rr_css got=%b exp=%b", css_v, e_css); end
    checks++;
    if (x0_v !== e_x0) begin failures++; $display("FAIL rr_csx0 got=%b exp=%b", x0_v, e_x0); end
    checks++;
    if (cack_v !== e_cack) begin failures++; $display("FAIL rr_cpu_ack got=%b exp=%b", cack_v, e_cack); end
    checks++;
    if (dack_v !== e_dack) begin failures++; $display("FAIL rr_dma_ack got=%b exp=%b", dack_v, e_dack); end
    checks++;
    if (multi !== 0) begin failures++; $display("FAIL rr_multi_cs got=%0d exp=0", multi); end
  endtask
  task automatic test_dma_stream;
    int ack_at[4];
    logic [15:0] got[4];
    int n;
    logic oe_seen, wrong_cs;
    n = 0;
    oe_seen = 1'b0;
    wrong_cs = 1'b0;
    PD_IN = 16'hA000;
    DMA_RW = 1'b1;
    DMA_REQ = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      step;
      if (PD_OE) oe_seen = 1'b1;
      if (!_CSS || !_CSX1 || !_IOW) wrong_cs = 1'b1;
      if (DMA_ACK && n < 4) begin
        ack_at[n] = i;
        got[n] = DMA_RDATA;
        n++;
        PD_IN = 16'hA000 + 16'(n);
        if (n == 4) DMA_REQ = 1'b0;
      end
    end
    DMA_REQ = 1'b0;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (n <= j || ack_at[j] !== 5 + 6 * j) begin
        failures++;
        $display("FAIL dma_ack_time[%0d] got=%0d exp=%0d", j, n <= j ? -1 : ack_at[j], 5 + 6 * j);
      end
      checks++;
      if (n <= j || got[j] !== 16'hA000 + 16'(j)) begin
        failures++;
        $display("FAIL dma_rdata[%0d] got=%h exp=%h", j, n <= j ? 16'hxxxx : got[j], 16'hA000 + 16'(j));
      end
    end
    checks++;
    if (oe_seen !== 1'b0) begin failures++; $display("FAIL dma_oe got=%b exp=0", oe_seen); end
    checks++;
    if (wrong_cs !== 1'b0) begin failures++; $display("FAIL dma_wrong_pin got=%b exp=0", wrong_cs); end
  endtask
  task automatic test_reset_mid;
    logic [8:1] css_v, ack_v;
    logic stray_ack;
    stray_ack = 1'b0;
    CPU_RW = 1'b0;
    CPU_ADDR = 5'h10;
    CPU_WDATA = 16'h5A5A;
    CPU_REQ = 1'b1;
    repeat (3) step;
    checks++;
    if (_IOW !== 1'b0) begin failures++; $display("FAIL rst_mid_in_strobe got=%b exp=0", _IOW); end
    RST = 1'b1;
    CPU_REQ = 1'b0;
    step;
    checks++;
    if ({_CSS, _CSX0, _CSX1, _IOR, _IOW, PD_OE, CPU_ACK} !== 7'b1111100) begin
      failures++;
      $display("FAIL rst_mid_pins got=%b exp=1111100", {_CSS, _CSX0, _CSX1, _IOR, _IOW, PD_OE, CPU_ACK});
    end
    RST = 1'b0;
    repeat (4) begin
      step;
      if (CPU_ACK) stray_ack = 1'b1;
    end
    checks++;
    if (stray_ack !== 1'b0) begin failures++; $display("FAIL rst_mid_no_ack got=%b exp=0", stray_ack); end
    CPU_REQ = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step;
      css_v[i] = _CSS;
      ack_v[i] = CPU_ACK;
      if (CPU_ACK) CPU_REQ = 1'b0;
    end
    checks++;
    if (css_v !== 8'b11100000) begin failures++; $display("FAIL rst_reissue_css got=%b exp=11100000", css_v); end
    checks++;
    if (ack_v !== 8'b00010000) begin failures++; $display("FAIL rst_reissue_ack got=%b exp=00010000", ack_v); end
  endtask
  initial begin
    test_reset;
    test_cpu_write;
    test_cpu_read;
    test_decode_miss;
    test_round_robin;
    test_dma_stream;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scsi_port_arbiter.md
# scsi_port_arbiter

- Shares the 16-bit SCSI peripheral port (WD33C93 at `_CSS`, external devices at `_CSX0`/`_CSX1`) between two requesters: CPU register accesses and the DMA engine's FIFO↔SCSI data transfers.
- Arbitrates between them round-robin and runs each granted access as a timed setup/strobe/hold cycle that drives the chip selects, `_IOR`/`_IOW` and the data-bus enable.
- Sits between the CPU bus interface, the DMA FIFO controller and the pins of the peripheral data bus.

## Interface

Parameters:
- `SETUP_CYC`, default 1: CLK cycles from chip select to strobe. Legal range 1–15.
- `STROBE_CYC`, default 3: CLK cycles `_IOR`/`_IOW` are held low. Legal range 1–15.
- `HOLD_CYC`, default 1: CLK cycles chip select and write data are held after the strobe. Legal range 1–15.

Ports:
- `CLK` in 1: single clock. All logic is on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `CPU_REQ` in 1: CPU access request. Level-sensitive.
- `CPU_RW` in 1: 1 = read, 0 = write.
- `CPU_ADDR` in 5: CPU byte address bits [6:2].
- `CPU_WDATA` in 16: CPU write data.
- `CPU_ACK` out 1: one-cycle pulse; the access is complete.
- `CPU_RDATA` out 16: read data. Valid while `CPU_ACK` is high; holds its value afterwards.
- `DMA_REQ` in 1: DMA transfer request. Level-sensitive.
- `DMA_RW` in 1: 1 = read from SCSI, 0 = write to SCSI.
- `DMA_WDATA` in 16: DMA write data.
- `DMA_ACK` out 1: one-cycle completion pulse.
- `DMA_RDATA` out 16: read data. Valid while `DMA_ACK` is high.
- `_CSS`, `_CSX0`, `_CSX1` out 1 each: active-low chip selects.
- `_IOR`, `_IOW` out 1 each: active-low strobes.
- `PD_OUT` out 16: peripheral bus drive data.
- `PD_OE` out 1: peripheral bus output enable. High during write cycles.
- `PD_IN` in 16: peripheral bus sampled data.

## Operation

- **States:** IDLE, SETUP, STROBE, HOLD. A cycle counter is loaded with the phase length on every state entry.
- **Arbitration (IDLE only):**
  - Request pending on one side only: that side is granted.
  - Both pending: grant the side not granted last.
  - `last_grant` resets to DMA, so the CPU wins the first tie.
- **Latching at grant:** RW, address and write data are latched. Requesters hold them stable until ACK anyway.
- **CPU address decode** on `CPU_ADDR[4:2]` (byte addresses):
  - `10x` (0x40–0x5F) → `_CSS`.
  - `110` (0x60–0x6F) → `_CSX0`.
  - `111` (0x70–0x7F) → `_CSX1`.
  - `0xx` (below 0x40) → decode miss: no port cycle, `CPU_RDATA` = 0, `CPU_ACK` pulses on the next cycle, return to IDLE.
- **DMA** always uses `_CSX0`.
- **SETUP:** selected CS low. For writes, `PD_OE` = 1 and `PD_OUT` = latched data.
- **STROBE:** CS low; `_IOR` low (read) or `_IOW` low (write). Read data is captured from `PD_IN` on the final STROBE clock edge.
- **HOLD:** CS low, strobes high. Write data and `PD_OE` are held. On the last HOLD cycle, the granted side's ACK pulses; the next state is IDLE.
- **Back-to-back requests:** a REQ still high in the cycle after ACK counts as a new request. IDLE always lasts at least 1 cycle, which gives strobe recovery.
- **Mutual exclusion:** at most one CS low at any time. `_IOR` and `_IOW` are never low together. `PD_OE` is never 1 during a read.

## Timing

- **Reset values:** all chip selects, `_IOR` and `_IOW` = 1; `PD_OE` = 0; `PD_OUT` = 0; both ACKs = 0; both RDATA = 0; state IDLE; `last_grant` = DMA.
- **Reset mid-cycle:** outputs return to reset values on the same edge that samples `RST`. No ACK is issued and the access is abandoned. The requester re-issues after reset.
- **Latency:** REQ high at edge k (in IDLE) gives SETUP during cycles k+1 … k+SETUP_CYC, then STROBE, then HOLD.
  - ACK is high in cycle k + SETUP_CYC + STROBE_CYC + HOLD_CYC.
  - With default parameters, ACK is high in cycle k+5.
- **Decode miss:** ACK is high in cycle k+1.
- **Outputs:** all outputs are registered. No combinational path from any input to any output.

## Structure

- **Package `sdmac_pkg`** holds:
  - the state enum (IDLE/SETUP/STROBE/HOLD);
  - the requester enum (CPU/DMA);
  - the chip-select one-hot constants (CS_SCSI = 3'b110, CS_X0 = 3'b101, CS_X1 = 3'b011, CS_NONE = 3'b111);
  - the address decode constants for 0x40/0x60/0x70.
- **Sub-module `port_cycle_timer`:** a 4-bit loadable down-counter with a `done` output, instantiated once. The FSM loads the phase length and advances on `done`.

## Test plan

1. **CPU write, address 0x40, data 0xFF40, defaults.** `_CSS` low for 5 cycles. `_IOW` low for exactly 3 cycles, starting 1 cycle after `_CSS`. `PD_OUT` = 0xFF40 with `PD_OE` = 1 throughout. `CPU_ACK` pulses at k+5.
2. **CPU read, address 0x70, `PD_IN` = 0x1234.** `_CSX1` low and `_IOR` low for 3 cycles. `PD_OE` stays 0. `CPU_RDATA` = 0x1234 when `CPU_ACK` pulses.
3. **`CPU_REQ` and `DMA_REQ` rise together after reset, both held high.**
   - Grants alternate CPU, DMA, CPU, DMA.
   - Every DMA cycle uses `_CSX0`.
   - Each IDLE gap is at least 1 cycle.
   - Never two CS low at once.
4. **DMA read stream of 4 words, `PD_IN` = 0xA000 + n.** `DMA_RDATA` sequence is 0xA000–0xA003. ACK pulses are 6 cycles apart.
5. **CPU access to address 0x10.** No CS or strobe activity. `CPU_ACK` at k+1 with `CPU_RDATA` = 0.
6. **`RST` asserted during the STROBE of a CPU write.** On the next edge all CS and `_IOW` = 1 and `PD_OE` = 0. No `CPU_ACK` is issued. A re-issued request completes normally.
